// File: rtl/cmp_seq_pkg.sv
// Shared types and helpers for the digit-serial magnitude comparator.
package cmp_seq_pkg;

    // Controller states: waiting, scanning digits, reporting the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // Ceiling log2, used to size the digit counter so it can hold NDIG.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = 1;
        while (v < n) begin
            v = v * 2;
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/cmp_seq_digit_cmp.sv
// Combinational unsigned compare of one D-bit digit pair.
module digit_cmp #(
    parameter int D = 4
) (
    input  logic [D-1:0] x,
    input  logic [D-1:0] y,
    output logic         eq,
    output logic         gt
);

    assign eq = (x == y);
    assign gt = (x > y);

endmodule

// File: rtl/cmp_seq.sv
// Digit-serial magnitude comparator: walks two W-bit operands D bits per
// clock from the most significant digit and stops at the first difference.
// Signed operands are handled by flipping the sign bit at load, which maps
// two's complement onto offset binary so the unsigned digit walk still works.
module cmp_seq
    import cmp_seq_pkg::*;
#(
    parameter int W = 16,
    parameter int D = 4,
    localparam int NDIG = W / D,
    localparam int DW = clog2(NDIG + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          start,
    input  logic          signed_mode,
    input  logic [W-1:0]  a,
    input  logic [W-1:0]  b,
    output logic          ready,
    output logic          done,
    output logic          aeqb,
    output logic          agtb,
    output logic          altb,
    output logic [DW-1:0] digits
);

    state_t        state;
    state_t        state_nx;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  a_nx;
    logic [W-1:0]  b_nx;
    logic          aeqb_nx;
    logic          agtb_nx;
    logic          altb_nx;
    logic [DW-1:0] digits_nx;
    logic [W-1:0]  sign_flip;
    logic          dig_eq;
    logic          dig_gt;

    assign sign_flip = W'(signed_mode) << (W - 1);
    assign ready     = (state != SCAN);
    assign done      = (state == DONE);

    digit_cmp #(.D(D)) u_digit (
        .x  (a_r[W-1 -: D]),
        .y  (b_r[W-1 -: D]),
        .eq (dig_eq),
        .gt (dig_gt)
    );

    // Next-state, operand shifting, result flags and digit counting.
    always_comb begin
        state_nx  = state;
        a_nx      = a_r;
        b_nx      = b_r;
        aeqb_nx   = aeqb;
        agtb_nx   = agtb;
        altb_nx   = altb;
        digits_nx = digits;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nx  = SCAN;
                    a_nx      = a ^ sign_flip;
                    b_nx      = b ^ sign_flip;
                    aeqb_nx   = 1'b0;
                    agtb_nx   = 1'b0;
                    altb_nx   = 1'b0;
                    digits_nx = '0;
                end else if (state == DONE) begin
                    state_nx = IDLE;
                end
            end
            SCAN: begin
                digits_nx = digits + DW'(1);
                if (!dig_eq) begin
                    agtb_nx  = dig_gt;
                    altb_nx  = !dig_gt;
                    state_nx = DONE;
                end else if (digits == DW'(NDIG - 1)) begin
                    aeqb_nx  = 1'b1;
                    state_nx = DONE;
                end else begin
                    a_nx = a_r << D;
                    b_nx = b_r << D;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            aeqb   <= 1'b0;
            agtb   <= 1'b0;
            altb   <= 1'b0;
            digits <= '0;
        end else begin
            state  <= state_nx;
            a_r    <= a_nx;
            b_r    <= b_nx;
            aeqb   <= aeqb_nx;
            agtb   <= agtb_nx;
            altb   <= altb_nx;
            digits <= digits_nx;
        end
    end

endmodule

// File: tb/tb_cmp_seq.sv
// Self-checking bench for cmp_seq (W=16, D=4) against an arithmetic model.
module tb_cmp_seq;

    localparam int W = 16;
    localparam int D = 4;
    localparam int NDIG = W / D;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        signed_mode;
    logic [15:0] a;
    logic [15:0] b;
    logic        ready;
    logic        done;
    logic        aeqb;
    logic        agtb;
    logic        altb;
    logic [2:0]  digits;

    int checks;
    int errors;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        sm;
        logic [2:0]  fl;
        int          k;
    } vec_t;

    cmp_seq #(.W(W), .D(D)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .ready       (ready),
        .done        (done),
        .aeqb        (aeqb),
        .agtb        (agtb),
        .altb        (altb),
        .digits      (digits)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: flags {eq,gt,lt} from integer compare; digits examined is the
    // digit holding the most significant differing bit, or NDIG when equal.
    function automatic void model(input logic [15:0] ma, input logic [15:0] mb,
                                  input logic sm, output logic [2:0] fl,
                                  output int k);
        logic [15:0] x;
        int p;
        x = ma ^ mb;
        if (x == 16'h0) begin
            fl = 3'b100;
            k  = NDIG;
        end else begin
            p = 0;
            for (int i = 0; i < W; i++) if (x[i]) p = i;
            k = (W - 1 - p) / D + 1;
            if (sm) fl = ($signed(ma) > $signed(mb)) ? 3'b010 : 3'b001;
            else    fl = (ma > mb) ? 3'b010 : 3'b001;
        end
    endfunction

    // Launch one compare and wait (bounded) for done; lat counts clocks from
    // the acceptance edge to the edge that raises done, or -1 on timeout.
    task automatic applyStimulus(input logic [15:0] sa, input logic [15:0] sb,
                                 input logic sm, output int lat);
        start       = 1'b1;
        a           = sa;
        b           = sb;
        signed_mode = sm;
        @(posedge clk); #1;
        start       = 1'b0;
        a           = 16'($urandom);
        b           = 16'($urandom);
        signed_mode = ~sm;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done && lat < 0) lat = i;
            if (lat >= 0) break;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b exp=1", ready); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done got=%b exp=0", done); end
        checks++;
        if ({aeqb, agtb, altb} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got=%b exp=000", {aeqb, agtb, altb}); end
        checks++;
        if (digits !== 3'd0) begin errors++; $display("[TB] FAIL reset_digits got=%0d exp=0", digits); end
        reset_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        vec_t tbl[5];
        int lat;
        tbl[0] = '{16'h1234, 16'h1234, 1'b0, 3'b100, 4};
        tbl[1] = '{16'h9000, 16'h1000, 1'b0, 3'b010, 1};
        tbl[2] = '{16'h9000, 16'h1000, 1'b1, 3'b001, 1};
        tbl[3] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b010, 4};
        tbl[4] = '{16'h12F0, 16'h12E0, 1'b0, 3'b010, 3};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(tbl[i].a, tbl[i].b, tbl[i].sm, lat);
            checks++;
            if (lat !== tbl[i].k) begin errors++; $display("[TB] FAIL dir%0d_latency got=%0d exp=%0d", i, lat, tbl[i].k); end
            checks++;
            if ({aeqb, agtb, altb} !== tbl[i].fl) begin errors++; $display("[TB] FAIL dir%0d_flags got=%b exp=%b", i, {aeqb, agtb, altb}, tbl[i].fl); end
            checks++;
            if (int'(digits) !== tbl[i].k) begin errors++; $display("[TB] FAIL dir%0d_digits got=%0d exp=%0d", i, digits, tbl[i].k); end
        end
    endtask

    task automatic test_hold();
        int lat;
        applyStimulus(16'h12F0, 16'h12E0, 1'b0, lat);
        checks++;
        if (lat !== 3) begin errors++; $display("[TB] FAIL hold_latency got=%0d exp=3", lat); end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if ({done, ready, aeqb, agtb, altb, digits} !== {1'b0, 1'b1, 3'b010, 3'd3}) begin
                errors++;
                $display("[TB] FAIL hold_cycle%0d got=%b exp=%b", i,
                         {done, ready, aeqb, agtb, altb, digits}, {1'b0, 1'b1, 3'b010, 3'd3});
            end
        end
    endtask

    task automatic test_start_during_scan();
        int ndone;
        int first;
        start = 1'b1; a = 16'h1234; b = 16'h1234; signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (ready !== 1'b0) begin errors++; $display("[TB] FAIL scan_ready got=%b exp=0", ready); end
        @(posedge clk); #1;
        start = 1'b1; a = 16'h0000; b = 16'hFFFF; signed_mode = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        ndone = 0;
        first = -1;
        for (int i = 3; i <= 14; i++) begin
            @(posedge clk); #1;
            if (done) begin
                ndone++;
                if (first < 0) first = i;
                checks++;
                if ({aeqb, agtb, altb, digits} !== {3'b100, 3'd4}) begin
                    errors++;
                    $display("[TB] FAIL scan_ignore_result got=%b exp=%b", {aeqb, agtb, altb, digits}, {3'b100, 3'd4});
                end
            end
        end
        checks++;
        if (ndone !== 1) begin errors++; $display("[TB] FAIL scan_ignore_dones got=%0d exp=1", ndone); end
        checks++;
        if (first !== 4) begin errors++; $display("[TB] FAIL scan_ignore_latency got=%0d exp=4", first); end
    endtask

    task automatic test_reset_abort();
        int ndone;
        start = 1'b1; a = 16'hABCD; b = 16'hABCD; signed_mode = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        checks++;
        if ({ready, done, aeqb, agtb, altb} !== 5'b10000) begin
            errors++;
            $display("[TB] FAIL abort_state got=%b exp=10000", {ready, done, aeqb, agtb, altb});
        end
        checks++;
        if (digits !== 3'd0) begin errors++; $display("[TB] FAIL abort_digits got=%0d exp=0", digits); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin errors++; $display("[TB] FAIL abort_no_done got=%0d exp=0", ndone); end
    endtask

    task automatic test_back_to_back();
        int lat;
        start = 1'b1; a = 16'h9000; b = 16'h1000; signed_mode = 1'b0;
        @(posedge clk); #1;
        a = 16'h0001; b = 16'h0002;
        @(posedge clk); #1;
        checks++;
        if ({done, agtb, digits} !== {1'b1, 1'b1, 3'd1}) begin
            errors++;
            $display("[TB] FAIL b2b_first got=%b exp=%b", {done, agtb, digits}, {1'b1, 1'b1, 3'd1});
        end
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({done, ready, aeqb, agtb, altb, digits} !== {1'b0, 1'b0, 3'b000, 3'd0}) begin
            errors++;
            $display("[TB] FAIL b2b_cleared got=%b exp=%b", {done, ready, aeqb, agtb, altb, digits}, {1'b0, 1'b0, 3'b000, 3'd0});
        end
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (done && lat < 0) lat = i;
            if (lat >= 0) break;
        end
        checks++;
        if (lat !== 4) begin errors++; $display("[TB] FAIL b2b_latency got=%0d exp=4", lat); end
        checks++;
        if ({aeqb, agtb, altb, digits} !== {3'b001, 3'd4}) begin
            errors++;
            $display("[TB] FAIL b2b_second got=%b exp=%b", {aeqb, agtb, altb, digits}, {3'b001, 3'd4});
        end
    endtask

    task automatic test_random();
        logic [15:0] ra;
        logic [15:0] rb;
        logic [15:0] mask;
        logic        sm;
        logic [2:0]  efl;
        int          ek;
        int          lat;
        int          r;
        for (int n = 0; n < 40; n++) begin
            ra   = 16'($urandom);
            r    = int'($urandom_range(0, 4));
            mask = (r == 0) ? 16'h0000 : (16'hFFFF >> (4 * (r - 1)));
            rb   = ra ^ (16'($urandom) & mask);
            sm   = 1'($urandom);
            model(ra, rb, sm, efl, ek);
            applyStimulus(ra, rb, sm, lat);
            checks++;
            if (lat !== ek) begin errors++; $display("[TB] FAIL rnd%0d_latency a=%h b=%h s=%b got=%0d exp=%0d", n, ra, rb, sm, lat, ek); end
            checks++;
            if ({aeqb, agtb, altb} !== efl) begin errors++; $display("[TB] FAIL rnd%0d_flags a=%h b=%h s=%b got=%b exp=%b", n, ra, rb, sm, {aeqb, agtb, altb}, efl); end
            checks++;
            if (int'(digits) !== ek) begin errors++; $display("[TB] FAIL rnd%0d_digits a=%h b=%h s=%b got=%0d exp=%0d", n, ra, rb, sm, digits, ek); end
            if ($urandom_range(0, 1) == 1) begin
                @(posedge clk); #1;
            end
        end
    endtask

    // Run every scenario in order, then report.
    initial begin
        checks      = 0;
        errors      = 0;
        reset_n     = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = 16'h0;
        b           = 16'h0;
        test_reset();
        test_directed();
        test_hold();
        test_start_during_scan();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmp_seq.md
Name: cmp_seq

Overview:
Parametrised, digit-serial magnitude comparator. It is the next-generation, sequential successor to the fixed-width equality comparators.
- Compares two W-bit operands, D bits per clock, MSB digit first.
- Terminates early at the first unequal digit.
- Reports equal, greater or less, with a start/done handshake.
- Supports unsigned and two's-complement operands.
- Used where wide compares must fit a small LUT budget and the caller can tolerate multi-cycle latency.

Parameters:
- W, 16, operand width in bits; must be a multiple of D.
- D, 4, digit width compared per cycle; 1 ≤ D ≤ W.
- NDIG (localparam), W/D, number of digits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  synchronous, active-low reset.
- start  in  1  request a compare; accepted only when ready=1.
- signed_mode  in  1  1 = two's-complement compare; sampled with start.
- a  in  W  operand A; sampled only in the acceptance cycle.
- b  in  W  operand B; sampled only in the acceptance cycle.
- ready  out  1  block can accept start (state IDLE or DONE).
- done  out  1  one-cycle pulse; result flags valid from this cycle.
- aeqb  out  1  A == B.
- agtb  out  1  A > B.
- altb  out  1  A < B.
- digits  out  clog2(NDIG+1)  number of digits examined by the last compare.

Behaviour:
- Reset is synchronous and active-low. With reset_n=0 at a clk edge:
  - state = IDLE
  - ready = 1, done = 0
  - aeqb = agtb = altb = 0
  - digits = 0
  - shift registers cleared
- FSM states: IDLE, SCAN, DONE.
  - IDLE, start=1 → SCAN. Load shift regs A_r, B_r; clear flags and digits. In signed mode, invert bit W-1 of both operands at load (offset-binary), then run the unsigned compare.
  - SCAN: each cycle, compare the top D bits of A_r and B_r and increment digits.
    - Digits unequal → set agtb or altb by the digit compare → DONE.
    - Digits equal, and this is the last digit (digits reaches NDIG) → set aeqb → DONE.
    - Otherwise shift A_r and B_r left by D and stay in SCAN.
  - DONE: done=1 for exactly this cycle. start=1 → SCAN (back-to-back accept, same load rules); else → IDLE.
- Latency: start accepted in cycle t, k digits examined (1..NDIG) → done in cycle t+1+k. Worst case t+1+NDIG.
- Flags are one-hot once done has pulsed. They hold, with digits, until the next accepted start, which clears them in the cycle after acceptance.
- start while in SCAN (ready=0) is ignored and has no side effects. a, b and signed_mode changes during SCAN have no effect.
- reset_n=0 during SCAN aborts the compare: no done pulse, and ready=1 from the next cycle.
- D=W degenerates to single-digit compare: done at t+2 always.
- Widths: the digit compare is pure unsigned D-bit. The digits counter never exceeds NDIG.

Decomposition:
- Shared include cmp_defs.vh holds:
  - state encoding localparams (IDLE=2'd0, SCAN=2'd1, DONE=2'd2)
  - a clog2 function macro for digits width.
- Sub-module digit_cmp #(D): combinational D-bit compare with outputs eq and gt. It generalises the per-bit equality cells. cmp_seq instantiates one copy on the top digits of A_r/B_r.
- The FSM, shift registers and counter stay in cmp_seq.

Test Plan:
All scenarios use W=16, D=4; start is accepted in cycle t.
1. Unsigned, a=0x1234, b=0x1234 → done in t+5; aeqb=1, agtb=altb=0, digits=4.
2. Unsigned, a=0x9000, b=0x1000 → done in t+2; agtb=1, digits=1.
3. Signed, a=0x9000, b=0x1000 → done in t+2; altb=1 (negative < positive), digits=1. Also signed, a=0xFFFF, b=0xFFFE → agtb=1, digits=4, done in t+5.
4. Unsigned, a=0x12F0, b=0x12E0 → done in t+4; agtb=1, digits=3. Flags stay stable for 10 idle cycles afterwards.
5. Start pulsed during SCAN → ignored, single done. Separately, reset_n=0 for one cycle in the second SCAN cycle → no done; ready=1 and all flags 0 the following cycle.
6. Back-to-back: start held high across DONE with new operands a=0x0001, b=0x0002 → second compare accepted in the DONE cycle, flags cleared next cycle, altb=1 with digits=4 at done.
